io_test_sequencer: RTL and testbench

//  Controller for the board external-IO test bank. Drives all test pins (io_out) through a

---
 rtl/io_test_sequencer.sv | 159 +++++++++++++++
 tb/tb_io_test_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_test_sequencer.sv
// io_test_sequencer: key-advanced pattern sequencer for the external-IO test bank.
// Define IO_TEST_PRBS_EN to add the PRBS mode (4) after HOLD.
module io_test_sequencer #(
    parameter int IO_W        = 70,
    parameter int STEP_CYCLES = 25_000_000,
    parameter int DEB_CYCLES  = 1_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key,
    input  logic            pause,
    output logic [IO_W-1:0] io_out,
    output logic [2:0]      mode,
    output logic            step_tick
);
    localparam int TW = $clog2(STEP_CYCLES);
    localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
    localparam int PW = IO_W > 1 ? $clog2(IO_W) : 1;
    localparam logic [IO_W-1:0] ONE = IO_W'(1);

    typedef enum logic [2:0] {ALT = 3'd0, WALK1 = 3'd1, WALK0 = 3'd2, HOLD = 3'd3, PRBS = 3'd4} mode_t;

    function automatic logic [IO_W-1:0] alt_pat();
        logic [IO_W-1:0] p;
        for (int i = 0; i < IO_W; i++) p[i] = i[0];
        return p;
    endfunction

    localparam logic [IO_W-1:0] ALT0 = alt_pat();

`ifdef IO_TEST_PRBS_EN
    localparam logic [15:0] SEED = 16'hACE1;

    function automatic logic [IO_W-1:0] prbs_map(input logic [15:0] l);
        logic [IO_W-1:0] p;
        for (int i = 0; i < IO_W; i++) p[i] = l[i % 16];
        return p;
    endfunction

    logic [15:0] lfsr, lfsr_n;
    assign lfsr_n = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`endif

    logic          key_s1, key_s2, deb_level, press, deb_done;
    logic [DW-1:0] deb_cnt;

    // Counter runs only while the synced key disagrees with the debounced level.
    assign deb_done = key_s2 != deb_level && deb_cnt == DW'(DEB_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            deb_level <= 1'b1;
            deb_cnt   <= '0;
            press     <= 1'b0;
        end else begin
            key_s1    <= key;
            key_s2    <= key_s1;
            deb_cnt   <= key_s2 == deb_level || deb_done ? '0 : deb_cnt + DW'(1);
            deb_level <= deb_done ? key_s2 : deb_level;
            press     <= deb_done && deb_level;
        end
    end

    mode_t           state, nxt;
    logic [TW-1:0]   timer;
    logic [PW-1:0]   pos, pos_n;
    logic            phase, tc;
    logic [IO_W-1:0] entry;

    assign mode  = state;
    assign tc    = !pause && timer == TW'(STEP_CYCLES - 1);
    assign pos_n = pos == PW'(IO_W - 1) ? '0 : pos + PW'(1);

    always_comb begin
        nxt = ALT;
        case (state)
            ALT:     nxt = WALK1;
            WALK1:   nxt = WALK0;
            WALK0:   nxt = HOLD;
`ifdef IO_TEST_PRBS_EN
            HOLD:    nxt = PRBS;
`endif
            default: nxt = ALT;
        endcase
    end

    always_comb begin
        entry = ALT0;
        case (nxt)
            WALK1:   entry = ONE;
            WALK0:   entry = ~ONE;
            HOLD:    entry = '1;
`ifdef IO_TEST_PRBS_EN
            PRBS:    entry = prbs_map(SEED);
`endif
            default: entry = ALT0;
        endcase
    end

    // A press restarts the new mode from its entry pattern and swallows a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ALT;
            timer     <= '0;
            pos       <= '0;
            phase     <= 1'b0;
            step_tick <= 1'b0;
            io_out    <= ALT0;
`ifdef IO_TEST_PRBS_EN
            lfsr      <= SEED;
`endif
        end else if (press) begin
            state     <= nxt;
            timer     <= '0;
            pos       <= '0;
            phase     <= 1'b0;
            step_tick <= 1'b0;
            io_out    <= entry;
`ifdef IO_TEST_PRBS_EN
            lfsr      <= SEED;
`endif
        end else if (tc) begin
            timer     <= '0;
            step_tick <= 1'b1;
            case (state)
                ALT: begin
                    phase  <= ~phase;
                    io_out <= phase ? ALT0 : ~ALT0;
                end
                WALK1: begin
                    pos    <= pos_n;
                    io_out <= ONE << pos_n;
                end
                WALK0: begin
                    pos    <= pos_n;
                    io_out <= ~(ONE << pos_n);
                end
                HOLD: io_out <= '1;
`ifdef IO_TEST_PRBS_EN
                PRBS: begin
                    lfsr   <= lfsr_n;
                    io_out <= prbs_map(lfsr_n);
                end
`endif
                default: begin
                    state  <= ALT;
                    pos    <= '0;
                    phase  <= 1'b0;
                    io_out <= ALT0;
                end
            endcase
        end else begin
            step_tick <= 1'b0;
            timer     <= pause ? timer : timer + TW'(1);
        end
    end
endmodule

// File: tb/tb_io_test_sequencer.sv
// tb_io_test_sequencer: directed and randomized checks of io_test_sequencer
// against a step-count reference model (IO_W=8, STEP_CYCLES=4, DEB_CYCLES=3).
module tb_io_test_sequencer;
    localparam int IO_W = 8;
    localparam int STEP = 4;
    localparam int DEB  = 3;
`ifdef IO_TEST_PRBS_EN
    localparam bit PRBS = 1'b1;
`else
    localparam bit PRBS = 1'b0;
`endif
    localparam logic [7:0] ENTRY [5] = '{8'hAA, 8'h01, 8'hFE, 8'hFF, 8'hE1};

    logic            clk = 1'b0, rst = 1'b1, key = 1'b1, pause = 1'b0;
    logic [IO_W-1:0] io_out;
    logic [2:0]      mode;
    logic            step_tick;
    int              checks = 0, errors = 0;

    int          m_mode, m_steps, m_timer, m_run;
    logic        m_tick, m_press, m_level, m_p;
    logic [1:0]  m_s;
    logic [15:0] m_lfsr;

    io_test_sequencer #(.IO_W(IO_W), .STEP_CYCLES(STEP), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .key(key), .pause(pause),
        .io_out(io_out), .mode(mode), .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    function automatic int next_mode(input int m);
        return m == 3 ? (PRBS ? 4 : 0) : m == 4 ? 0 : m + 1;
    endfunction

    // Expected pins from mode and number of ticks since mode entry.
    function automatic logic [7:0] exp_io();
        logic [7:0] one;
        one = 8'(1) << (m_steps % IO_W);
        case (m_mode)
            0:       return m_steps % 2 == 1 ? 8'h55 : 8'hAA;
            1:       return one;
            2:       return ~one;
            3:       return 8'hFF;
            default: return m_lfsr[7:0];
        endcase
    endfunction

    task automatic model_step();
        if (rst) begin
            m_s = 2'b11; m_level = 1'b1; m_run = 0; m_press = 1'b0;
            m_mode = 0; m_steps = 0; m_timer = 0; m_tick = 1'b0; m_lfsr = 16'hACE1;
        end else begin
            m_p = m_press;
            m_press = 1'b0;
            if (m_s[1] != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = m_s[1];
                    m_run = 0;
                    m_press = ~m_level;
                end
            end else m_run = 0;
            m_s = {m_s[0], key};
            if (m_p) begin
                m_mode = next_mode(m_mode); m_steps = 0; m_timer = 0; m_tick = 1'b0; m_lfsr = 16'hACE1;
            end else if (!pause && m_timer == STEP - 1) begin
                m_timer = 0; m_steps++; m_tick = 1'b1;
                m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            end else begin
                m_tick = 1'b0;
                if (!pause) m_timer++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic press_key();
        key = 1'b0;
        repeat (8) step();
        key = 1'b1;
    endtask

    task automatic wait_tick(output bit ok);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (step_tick !== 1'b1 && n < 12);
        ok = step_tick === 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (io_out !== 8'hAA) begin errors++; $display("FAIL reset_io: got %h want %h", io_out, 8'hAA); end
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", mode); end
        checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", step_tick); end
    endtask

    task automatic test_alt();
        repeat (3) begin
            step();
            checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL alt_early_tick: got %b want 0", step_tick); end
        end
        step();
        checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL alt_tick: got %b want 1", step_tick); end
        checks++; if (io_out !== 8'h55) begin errors++; $display("FAIL alt_invert: got %h want %h", io_out, 8'h55); end
        step();
        checks++; if (io_out !== 8'h55 || step_tick !== 1'b0) begin errors++; $display("FAIL alt_hold: got %h/%b want 55/0", io_out, step_tick); end
    endtask

    task automatic test_walk();
        logic [7:0] e;
        bit ok;
        key = 1'b0;
        repeat (5) step();
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL press_latency_early: got mode %0d want 0", mode); end
        step();
        checks++; if (mode !== 3'd1 || io_out !== 8'h01) begin errors++; $display("FAIL walk1_entry: got %0d/%h want 1/01", mode, io_out); end
        step(); step();
        key = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wait_tick(ok);
            e = 8'(1) << (k % 8);
            checks++; if (!ok || io_out !== e) begin errors++; $display("FAIL walk1_step%0d: got %h tick %b want %h", k, io_out, step_tick, e); end
        end
        press_key();
        checks++; if (mode !== 3'd2 || io_out !== 8'hFE) begin errors++; $display("FAIL walk0_entry: got %0d/%h want 2/FE", mode, io_out); end
        wait_tick(ok);
        checks++; if (!ok || io_out !== 8'hFD) begin errors++; $display("FAIL walk0_step: got %h want FD", io_out); end
    endtask

    task automatic test_glitch_hold();
        repeat (8) step();
        key = 1'b0;
        step(); step();
        key = 1'b1;
        repeat (10) step();
        checks++; if (mode !== 3'd2) begin errors++; $display("FAIL glitch_mode: got %0d want 2", mode); end
        checks++; if (io_out !== exp_io()) begin errors++; $display("FAIL glitch_io: got %h want %h", io_out, exp_io()); end
        key = 1'b0;
        repeat (100) step();
        key = 1'b1;
        repeat (10) step();
        checks++; if (mode !== 3'd3 || io_out !== 8'hFF) begin errors++; $display("FAIL hold_single_press: got %0d/%h want 3/FF", mode, io_out); end
    endtask

    task automatic test_pause();
        logic [7:0] saved;
        bit ok;
        press_key();
        repeat (8) step();
        checks++; if (mode !== 3'(next_mode(3))) begin errors++; $display("FAIL pause_setup_mode: got %0d want %0d", mode, next_mode(3)); end
        wait_tick(ok);
        checks++; if (!ok) begin errors++; $display("FAIL pause_tick_timeout: got tick %b want 1", step_tick); end
        step(); step();
        pause = 1'b1;
        saved = io_out;
        repeat (10) begin
            step();
            checks++; if (step_tick !== 1'b0 || io_out !== saved) begin errors++; $display("FAIL pause_hold: got %h/%b want %h/0", io_out, step_tick, saved); end
        end
        pause = 1'b0;
        step();
        checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL pause_resume_early: got %b want 0", step_tick); end
        step();
        checks++; if (step_tick !== 1'b1 || io_out !== exp_io()) begin errors++; $display("FAIL pause_resume_tick: got %h/%b want %h/1", io_out, step_tick, exp_io()); end
    endtask

    task automatic test_press_tick();
        int em;
        bit ok;
        repeat (8) step();
        wait_tick(ok);
        step(); step();
        em = next_mode(m_mode);
        key = 1'b0;
        repeat (5) step();
        checks++; if (!ok || step_tick !== 1'b0) begin errors++; $display("FAIL pt_setup: got tick %b want 0", step_tick); end
        step();
        checks++; if (mode !== 3'(em) || io_out !== ENTRY[em] || step_tick !== 1'b0) begin
            errors++; $display("FAIL press_wins: got %0d/%h/%b want %0d/%h/0", mode, io_out, step_tick, em, ENTRY[em]);
        end
        key = 1'b1;
        repeat (3) begin
            step();
            checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL pt_timer_cleared: got %b want 0", step_tick); end
        end
        step();
        checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL pt_next_tick: got %b want 1", step_tick); end
    endtask

`ifdef IO_TEST_PRBS_EN
    task automatic test_prbs();
        bit ok;
        repeat (8) step();
        for (int i = 0; i < 5 && m_mode != 3; i++) begin
            press_key();
            repeat (8) step();
        end
        press_key();
        checks++; if (mode !== 3'd4 || io_out !== 8'hE1) begin errors++; $display("FAIL prbs_entry: got %0d/%h want 4/E1", mode, io_out); end
        wait_tick(ok);
        checks++; if (!ok || io_out !== 8'h70) begin errors++; $display("FAIL prbs_step1: got %h want 70", io_out); end
        wait_tick(ok);
        checks++; if (!ok || io_out !== m_lfsr[7:0]) begin errors++; $display("FAIL prbs_step2: got %h want %h", io_out, m_lfsr[7:0]); end
        repeat (8) step();
        press_key();
        checks++; if (mode !== 3'd0 || io_out !== 8'hAA) begin errors++; $display("FAIL prbs_wrap: got %0d/%h want 0/AA", mode, io_out); end
        for (int i = 0; i < 4; i++) begin
            repeat (8) step();
            press_key();
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (mode !== 3'd0 || io_out !== 8'hAA || step_tick !== 1'b0) begin errors++; $display("FAIL prbs_reset: got %0d/%h/%b want 0/AA/0", mode, io_out, step_tick); end
    endtask
`endif

    task automatic test_reset_mid();
        repeat (8) step();
        step(); step();
        key = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (mode !== 3'd0 || io_out !== 8'hAA || step_tick !== 1'b0) begin errors++; $display("FAIL mid_reset: got %0d/%h/%b want 0/AA/0", mode, io_out, step_tick); end
        repeat (10) begin
            step();
            checks++; if (mode !== 3'(m_mode) || io_out !== exp_io()) begin errors++; $display("FAIL mid_reset_follow: got %0d/%h want %0d/%h", mode, io_out, m_mode, exp_io()); end
        end
        key = 1'b1;
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                key = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            pause = $urandom_range(0, 9) == 0;
            rst = $urandom_range(0, 299) == 0;
            step();
            checks++; if (mode !== 3'(m_mode)) begin errors++; $display("FAIL rand_mode@%0d: got %0d want %0d", i, mode, m_mode); end
            checks++; if (io_out !== exp_io()) begin errors++; $display("FAIL rand_io@%0d: got %h want %h", i, io_out, exp_io()); end
            checks++; if (step_tick !== m_tick) begin errors++; $display("FAIL rand_tick@%0d: got %b want %b", i, step_tick, m_tick); end
        end
        rst = 1'b0;
        pause = 1'b0;
        key = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alt();
        test_walk();
        test_glitch_hold();
        test_pause();
        test_press_tick();
`ifdef IO_TEST_PRBS_EN
        test_prbs();
`endif
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
